sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Owns the single SDRAM command/address/bank bus and shares it between four sequencers: power-up init, auto-refresh, write and read.
- Requesters raise a request. The arbiter returns a one-cycle grant, multiplexes the granted sequencer's command/address onto the pins until that sequencer signals completion, then returns to arbitration.
- Sits between the sequencer modules and the SDRAM pad ring. The init sequencer always runs first; after init, priority is refresh > write > read.

Parameters:
- ADDR_WIDTH, 12, SDRAM address bus width.
- BA_WIDTH, 2, bank address width.
- DATA_WIDTH, 16, DQ width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- init_end  in  1  init sequence complete (level, stays high)
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_addr  in  ADDR_WIDTH  init address (MRS value)
- ref_rq  in  1  refresh request, held until granted
- ref_end  in  1  refresh done, one-cycle pulse
- ref_cmd  in  4  refresh command
- ref_addr  in  ADDR_WIDTH  refresh address
- ref_en  out  1  refresh grant, one-cycle pulse
- wr_rq  in  1  write request, held until granted
- wr_end_flag  in  1  write burst done, one-cycle pulse
- wr_cmd  in  4  write command
- wr_addr  in  ADDR_WIDTH  write address
- wr_bank_addr  in  BA_WIDTH  write bank
- wr_data  in  DATA_WIDTH  write data
- wr_en  out  1  write grant, one-cycle pulse
- rd_rq  in  1  read request, held until granted
- rd_end_flag  in  1  read done, one-cycle pulse
- rd_cmd  in  4  read command
- rd_addr  in  ADDR_WIDTH  read address
- rd_bank_addr  in  BA_WIDTH  read bank
- rd_en  out  1  read grant, one-cycle pulse
- sdram_cke  out  1  clock enable
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
- sdram_addr  out  ADDR_WIDTH  address to pins
- sdram_ba  out  BA_WIDTH  bank to pins
- sdram_dq_out  out  DATA_WIDTH  write data to pins
- sdram_dq_oe  out  1  DQ output enable
- arb_state  out  3  current state, for debug

Behaviour:
- Reset: state=S_INIT. ref_en/wr_en/rd_en=0, sdram_cke=1, sdram_dq_oe=0.
- States and encoding: S_INIT=0, S_ARBIT=1, S_AREF=2, S_WRITE=3, S_READ=4. The state register is updated on posedge clk.
- S_INIT: pins = init_cmd/init_addr, ba=0. Move to S_ARBIT on the first cycle init_end=1. All requests are ignored while in S_INIT.
- S_ARBIT:
  - Pins = NOP (4'b0111), addr=0, ba=0.
  - Priority: ref_rq, then wr_rq, then rd_rq.
  - If the winner is sampled at cycle N, the state and matching grant pulse both appear at N+1. The grant is high exactly one cycle.
  - With no request, stay in S_ARBIT.
- S_AREF: pins = ref_cmd/ref_addr, ba=0. Exit to S_ARBIT on ref_end.
- S_WRITE: pins = wr_cmd/wr_addr/wr_bank_addr. sdram_dq_out=wr_data, sdram_dq_oe=1. Exit to S_ARBIT on wr_end_flag.
- S_READ: pins = rd_cmd/rd_addr/rd_bank_addr, sdram_dq_oe=0. Exit to S_ARBIT on rd_end_flag.
- The pin mux is combinational on the registered state, so it adds zero latency to sequencer commands. sdram_dq_out=0 outside S_WRITE.
- A granted sequencer is never preempted. Refresh urgency is handled by the sequencers themselves, which watch ref_rq and close their burst early.
- End flag and a pending request in the same cycle: the state goes to S_ARBIT first. At least one NOP cycle separates consecutive owners.
- End flags from a non-owner are ignored. Requests from non-owners stay pending and do not disturb the current owner.
- Reset asserted mid-transfer: return immediately to S_INIT and drive NOP. The init sequence must complete again before any grant.

Optional Feature:
- SDRAM_ARB_RR_EN.
- Defined: write and read alternate fairly. A last_wr bit is set when write is granted and cleared when read is granted; last_wr resets to 0. When both wr_rq and rd_rq are pending, the one not last served wins. Refresh keeps absolute priority.
- Undefined: fixed priority, write over read.

Test Plan:
- Reset, then init_cmd=4'b0000 with init_addr=12'h037 and init_end rising at cycle 20 -> pins follow init until cycle 20; state=S_ARBIT at 21; sdram_cmd=4'b0111.
- In S_ARBIT, ref_rq, wr_rq and rd_rq all high at cycle N -> ref_en=1 only at N+1 (wr_en=rd_en=0), state=S_AREF. After ref_end -> one S_ARBIT cycle, then wr_en pulse.
- Write ownership with wr_cmd=4'b0100, wr_bank_addr=2'b01, wr_data=16'hA5A5 -> pins match, dq_oe=1. rd_rq raised mid-burst -> no rd_en until one cycle after wr_end_flag.
- rd_end_flag pulsed while state=S_WRITE -> ignored, state stays S_WRITE.
- rst pulsed while in S_READ -> state=S_INIT next edge, sdram_cmd=NOP, dq_oe=0, no grants until init_end.
- With SDRAM_ARB_RR_EN, wr_rq and rd_rq held continuously -> grants alternate wr, rd, wr, rd. Without the macro, every grant is wr_en.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM command/address/bank bus between the init, refresh, write and read sequencers.
// Optional macro SDRAM_ARB_RR_EN: write and read alternate fairly instead of fixed write-over-read priority.
module sdram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned BA_WIDTH   = 2,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_end,
   input  logic [3:0]            init_cmd,
   input  logic [ADDR_WIDTH-1:0] init_addr,
   input  logic                  ref_rq,
   input  logic                  ref_end,
   input  logic [3:0]            ref_cmd,
   input  logic [ADDR_WIDTH-1:0] ref_addr,
   output logic                  ref_en,
   input  logic                  wr_rq,
   input  logic                  wr_end_flag,
   input  logic [3:0]            wr_cmd,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [BA_WIDTH-1:0]   wr_bank_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_en,
   input  logic                  rd_rq,
   input  logic                  rd_end_flag,
   input  logic [3:0]            rd_cmd,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [BA_WIDTH-1:0]   rd_bank_addr,
   output logic                  rd_en,
   output logic                  sdram_cke,
   output logic [3:0]            sdram_cmd,
   output logic [ADDR_WIDTH-1:0] sdram_addr,
   output logic [BA_WIDTH-1:0]   sdram_ba,
   output logic [DATA_WIDTH-1:0] sdram_dq_out,
   output logic                  sdram_dq_oe,
   output logic [2:0]            arb_state
);

   localparam int unsigned STATE_W = 3;
   localparam logic [3:0]  CMD_NOP = 4'b0111;

   typedef enum logic [STATE_W-1:0] {
      S_INIT  = 3'd0,
      S_ARBIT = 3'd1,
      S_AREF  = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4
   } state_t;

   state_t state, state_nxt;
   logic   ref_en_nxt, wr_en_nxt, rd_en_nxt;
   logic   wr_wins_c;
`ifdef SDRAM_ARB_RR_EN
   logic   last_wr, last_wr_nxt;
`endif

   // State, grant pulses and clock enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_INIT;
         ref_en    <= 1'b0;
         wr_en     <= 1'b0;
         rd_en     <= 1'b0;
         sdram_cke <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
         last_wr   <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         ref_en    <= ref_en_nxt;
         wr_en     <= wr_en_nxt;
         rd_en     <= rd_en_nxt;
         sdram_cke <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
         last_wr   <= last_wr_nxt;
`endif
      end
   end

   // Arbitration and ownership hand-back
   always_comb begin
      state_nxt  = state;
      ref_en_nxt = 1'b0;
      wr_en_nxt  = 1'b0;
      rd_en_nxt  = 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_wr_nxt = last_wr;
      wr_wins_c   = wr_rq && !(rd_rq && last_wr);
`else
      wr_wins_c   = wr_rq;
`endif
      case (state)
         S_INIT: begin
            if (init_end) state_nxt = S_ARBIT;
         end
         S_ARBIT: begin
            if (ref_rq) begin
               state_nxt  = S_AREF;
               ref_en_nxt = 1'b1;
            end else if (wr_wins_c) begin
               state_nxt = S_WRITE;
               wr_en_nxt = 1'b1;
`ifdef SDRAM_ARB_RR_EN
               last_wr_nxt = 1'b1;
`endif
            end else if (rd_rq) begin
               state_nxt = S_READ;
               rd_en_nxt = 1'b1;
`ifdef SDRAM_ARB_RR_EN
               last_wr_nxt = 1'b0;
`endif
            end
         end
         S_AREF: begin
            if (ref_end) state_nxt = S_ARBIT;
         end
         S_WRITE: begin
            if (wr_end_flag) state_nxt = S_ARBIT;
         end
         S_READ: begin
            if (rd_end_flag) state_nxt = S_ARBIT;
         end
         default: state_nxt = S_INIT;
      endcase
   end

   // Pin mux follows the registered owner; NOP while reset is held
   always_comb begin
      sdram_cmd    = CMD_NOP;
      sdram_addr   = '0;
      sdram_ba     = '0;
      sdram_dq_out = '0;
      sdram_dq_oe  = 1'b0;
      if (!rst) begin
         case (state)
            S_INIT: begin
               sdram_cmd  = init_cmd;
               sdram_addr = init_addr;
            end
            S_AREF: begin
               sdram_cmd  = ref_cmd;
               sdram_addr = ref_addr;
            end
            S_WRITE: begin
               sdram_cmd    = wr_cmd;
               sdram_addr   = wr_addr;
               sdram_ba     = wr_bank_addr;
               sdram_dq_out = wr_data;
               sdram_dq_oe  = 1'b1;
            end
            S_READ: begin
               sdram_cmd  = rd_cmd;
               sdram_addr = rd_addr;
               sdram_ba   = rd_bank_addr;
            end
            default: ;
         endcase
      end
   end

   assign arb_state = state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus randomized traffic against an ownership model.
`timescale 1ns/1ps
module tb_sdram_arbiter;
   localparam int unsigned AW = 12;
   localparam int unsigned BW = 2;
   localparam int unsigned DW = 16;
   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [2:0] ST_INIT = 3'd0, ST_ARBIT = 3'd1, ST_AREF = 3'd2, ST_WRITE = 3'd3, ST_READ = 3'd4;
`ifdef SDRAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk, rst;
   logic init_end; logic [3:0] init_cmd; logic [AW-1:0] init_addr;
   logic ref_rq, ref_end; logic [3:0] ref_cmd; logic [AW-1:0] ref_addr; logic ref_en;
   logic wr_rq, wr_end_flag; logic [3:0] wr_cmd; logic [AW-1:0] wr_addr; logic [BW-1:0] wr_bank_addr;
   logic [DW-1:0] wr_data; logic wr_en;
   logic rd_rq, rd_end_flag; logic [3:0] rd_cmd; logic [AW-1:0] rd_addr; logic [BW-1:0] rd_bank_addr; logic rd_en;
   logic sdram_cke; logic [3:0] sdram_cmd; logic [AW-1:0] sdram_addr; logic [BW-1:0] sdram_ba;
   logic [DW-1:0] sdram_dq_out; logic sdram_dq_oe; logic [2:0] arb_state;

   int n_checks = 0;
   int n_fail   = 0;
   bit m_last_wr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sdram_arbiter dut (
      .clk(clk), .rst(rst),
      .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
      .ref_rq(ref_rq), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr), .ref_en(ref_en),
      .wr_rq(wr_rq), .wr_end_flag(wr_end_flag), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
      .wr_bank_addr(wr_bank_addr), .wr_data(wr_data), .wr_en(wr_en),
      .rd_rq(rd_rq), .rd_end_flag(rd_end_flag), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
      .rd_bank_addr(rd_bank_addr), .rd_en(rd_en),
      .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
      .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .arb_state(arb_state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      init_end = 1'b0; init_cmd = NOP; init_addr = '0;
      ref_rq = 1'b0; ref_end = 1'b0; ref_cmd = NOP; ref_addr = '0;
      wr_rq = 1'b0; wr_end_flag = 1'b0; wr_cmd = NOP; wr_addr = '0; wr_bank_addr = '0; wr_data = '0;
      rd_rq = 1'b0; rd_end_flag = 1'b0; rd_cmd = NOP; rd_addr = '0; rd_bank_addr = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      init_cmd = 4'b0010;
      rst = 1'b1;
      step(); step();
      n_checks++;
      if (arb_state !== ST_INIT) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", arb_state, ST_INIT); end
      n_checks++;
      if ({ref_en, wr_en, rd_en} !== 3'b000) begin n_fail++; $display("FAIL reset_grants: got %b want 000", {ref_en, wr_en, rd_en}); end
      n_checks++;
      if ({sdram_cke, sdram_dq_oe} !== 2'b10) begin n_fail++; $display("FAIL reset_cke_oe: got %b want 10", {sdram_cke, sdram_dq_oe}); end
      n_checks++;
      if (sdram_cmd !== NOP) begin n_fail++; $display("FAIL reset_cmd: got %b want %b", sdram_cmd, NOP); end
      rst = 1'b0;
      m_last_wr = 1'b0;
   endtask

   task automatic test_init();
      int grants = 0;
      init_cmd = 4'b0000; init_addr = 12'h037; init_end = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         wr_rq  = (c >= 5 && c <= 10);
         ref_rq = (c == 7);
         if (c == 20) init_end = 1'b1;
         #1;
         n_checks++;
         if ({arb_state, sdram_cmd, sdram_addr, sdram_ba} !== {ST_INIT, 4'b0000, 12'h037, 2'b00}) begin
            n_fail++;
            $display("FAIL init_pins c%0d: got st=%0d cmd=%b addr=%h ba=%b want st=0 cmd=0000 addr=037 ba=00",
                     c, arb_state, sdram_cmd, sdram_addr, sdram_ba);
         end
         step();
         if (ref_en || wr_en || rd_en) grants++;
      end
      wr_rq = 1'b0; ref_rq = 1'b0;
      n_checks++;
      if (grants != 0) begin n_fail++; $display("FAIL init_no_grant: got %0d grants want 0", grants); end
      n_checks++;
      if ({arb_state, sdram_cmd, sdram_addr} !== {ST_ARBIT, NOP, 12'h000}) begin
         n_fail++;
         $display("FAIL init_exit: got st=%0d cmd=%b addr=%h want st=1 cmd=0111 addr=000", arb_state, sdram_cmd, sdram_addr);
      end
   endtask

   task automatic test_priority();
      ref_rq = 1'b1; wr_rq = 1'b1; rd_rq = 1'b1;
      step();
      n_checks++;
      if ({arb_state, ref_en, wr_en, rd_en} !== {ST_AREF, 3'b100}) begin
         n_fail++;
         $display("FAIL prio_ref: got st=%0d en=%b want st=2 en=100", arb_state, {ref_en, wr_en, rd_en});
      end
      ref_rq = 1'b0; ref_cmd = 4'b0001; ref_addr = 12'h400;
      #1;
      n_checks++;
      if ({sdram_cmd, sdram_addr, sdram_ba} !== {4'b0001, 12'h400, 2'b00}) begin
         n_fail++;
         $display("FAIL aref_pins: got cmd=%b addr=%h ba=%b want 0001/400/00", sdram_cmd, sdram_addr, sdram_ba);
      end
      step();
      n_checks++;
      if ({arb_state, ref_en} !== {ST_AREF, 1'b0}) begin
         n_fail++; $display("FAIL ref_pulse_len: got st=%0d ref_en=%b want st=2 ref_en=0", arb_state, ref_en);
      end
      ref_end = 1'b1;
      step();
      ref_end = 1'b0;
      n_checks++;
      if ({arb_state, sdram_cmd, wr_en, rd_en} !== {ST_ARBIT, NOP, 2'b00}) begin
         n_fail++;
         $display("FAIL ref_exit_gap: got st=%0d cmd=%b en=%b want st=1 cmd=0111 en=00", arb_state, sdram_cmd, {wr_en, rd_en});
      end
      step();
      n_checks++;
      if ({arb_state, ref_en, wr_en, rd_en} !== {ST_WRITE, 3'b010}) begin
         n_fail++;
         $display("FAIL prio_wr_after_ref: got st=%0d en=%b want st=3 en=010", arb_state, {ref_en, wr_en, rd_en});
      end
      m_last_wr = 1'b1;
      wr_rq = 1'b0;
   endtask

   task automatic test_write_ownership();
      wr_cmd = 4'b0100; wr_addr = 12'hABC; wr_bank_addr = 2'b01; wr_data = 16'hA5A5;
      #1;
      n_checks++;
      if ({sdram_cmd, sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe} !== {4'b0100, 12'hABC, 2'b01, 16'hA5A5, 1'b1}) begin
         n_fail++;
         $display("FAIL wr_pins: got cmd=%b addr=%h ba=%b dq=%h oe=%b want 0100/abc/01/a5a5/1",
                  sdram_cmd, sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({arb_state, rd_en} !== {ST_WRITE, 1'b0}) begin
            n_fail++; $display("FAIL wr_no_preempt: got st=%0d rd_en=%b want st=3 rd_en=0", arb_state, rd_en);
         end
      end
      rd_end_flag = 1'b1; ref_end = 1'b1;
      step();
      rd_end_flag = 1'b0; ref_end = 1'b0;
      n_checks++;
      if (arb_state !== ST_WRITE) begin n_fail++; $display("FAIL foreign_end: got st=%0d want 3", arb_state); end
      wr_end_flag = 1'b1;
      step();
      wr_end_flag = 1'b0;
      n_checks++;
      if ({arb_state, rd_en, sdram_dq_oe, sdram_dq_out} !== {ST_ARBIT, 1'b0, 1'b0, 16'h0000}) begin
         n_fail++;
         $display("FAIL wr_exit: got st=%0d rd_en=%b oe=%b dq=%h want st=1 rd_en=0 oe=0 dq=0000",
                  arb_state, rd_en, sdram_dq_oe, sdram_dq_out);
      end
      step();
      n_checks++;
      if ({arb_state, rd_en} !== {ST_READ, 1'b1}) begin
         n_fail++; $display("FAIL rd_grant: got st=%0d rd_en=%b want st=4 rd_en=1", arb_state, rd_en);
      end
      m_last_wr = 1'b0;
      rd_rq = 1'b0; rd_cmd = 4'b0101; rd_addr = 12'h123; rd_bank_addr = 2'b10;
      #1;
      n_checks++;
      if ({sdram_cmd, sdram_addr, sdram_ba, sdram_dq_oe} !== {4'b0101, 12'h123, 2'b10, 1'b0}) begin
         n_fail++;
         $display("FAIL rd_pins: got cmd=%b addr=%h ba=%b oe=%b want 0101/123/10/0", sdram_cmd, sdram_addr, sdram_ba, sdram_dq_oe);
      end
   endtask

   task automatic test_reset_mid_read();
      int grants = 0;
      init_cmd = 4'b0010; init_end = 1'b1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({arb_state, sdram_cmd} !== {ST_INIT, NOP}) begin
         n_fail++; $display("FAIL rst_async: got st=%0d cmd=%b want st=0 cmd=0111", arb_state, sdram_cmd);
      end
      step();
      n_checks++;
      if ({arb_state, sdram_cmd, sdram_dq_oe, ref_en, wr_en, rd_en} !== {ST_INIT, NOP, 4'b0000}) begin
         n_fail++;
         $display("FAIL rst_hold: got st=%0d cmd=%b oe=%b en=%b want st=0 cmd=0111 oe=0 en=000",
                  arb_state, sdram_cmd, sdram_dq_oe, {ref_en, wr_en, rd_en});
      end
      rst = 1'b0; init_end = 1'b0; wr_rq = 1'b1; rd_rq = 1'b1;
      m_last_wr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ref_en || wr_en || rd_en || arb_state !== ST_INIT) grants++;
      end
      n_checks++;
      if (grants != 0) begin n_fail++; $display("FAIL reinit_hold: got %0d bad cycles want 0", grants); end
      n_checks++;
      if (sdram_cmd !== 4'b0010) begin n_fail++; $display("FAIL reinit_pins: got cmd=%b want 0010", sdram_cmd); end
      init_end = 1'b1;
      step();
      step();
      n_checks++;
      if ({arb_state, wr_en, rd_en} !== {ST_WRITE, 2'b10}) begin
         n_fail++; $display("FAIL reinit_first: got st=%0d en=%b want st=3 en=10", arb_state, {wr_en, rd_en});
      end
      m_last_wr = 1'b1;
      wr_rq = 1'b0; wr_end_flag = 1'b1;
      step();
      wr_end_flag = 1'b0;
      step();
      n_checks++;
      if ({arb_state, rd_en} !== {ST_READ, 1'b1}) begin
         n_fail++; $display("FAIL reinit_rd: got st=%0d rd_en=%b want st=4 rd_en=1", arb_state, rd_en);
      end
      m_last_wr = 1'b0;
      rd_rq = 1'b0; rd_end_flag = 1'b1;
      step();
      rd_end_flag = 1'b0;
   endtask

   task automatic test_wr_rd_alternation();
      wr_rq = 1'b1; rd_rq = 1'b1;
      for (int g = 0; g < 6; g++) begin
         bit got = 1'b0;
         bit want_wr;
         for (int i = 0; i < 8 && !got; i++) begin
            step();
            if (ref_en || wr_en || rd_en) got = 1'b1;
         end
         n_checks++;
         if (!got) begin
            n_fail++; $display("FAIL alt_timeout grant%0d: got no grant want one within 8 cycles", g);
            break;
         end
         want_wr = RR ? !m_last_wr : 1'b1;
         n_checks++;
         if ({ref_en, wr_en, rd_en} !== {1'b0, want_wr, !want_wr}) begin
            n_fail++;
            $display("FAIL alt_grant%0d: got en=%b want en=%b", g, {ref_en, wr_en, rd_en}, {1'b0, want_wr, !want_wr});
         end
         m_last_wr = want_wr;
         step(); step();
         if (want_wr) wr_end_flag = 1'b1; else rd_end_flag = 1'b1;
         step();
         wr_end_flag = 1'b0; rd_end_flag = 1'b0;
      end
      wr_rq = 1'b0; rd_rq = 1'b0;
      step(); step();
   endtask

   task automatic test_random();
      bit [2:0] pend = 3'b000;
      logic [2:0] owner = ST_ARBIT;
      int cnt = 0;
      int errs = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic [2:0] exp_owner;
         logic [2:0] exp_en;
         logic [34:0] exp_pins;
         bit end_now;
         for (int k = 0; k < 3; k++)
            if (!pend[k] && owner != 3'(ST_AREF + k) && $urandom_range(0, 3) == 0) pend[k] = 1'b1;
         ref_rq = pend[0]; wr_rq = pend[1]; rd_rq = pend[2];
         end_now = (owner != ST_ARBIT) && (cnt == 0);
         ref_end     = (owner == ST_AREF)  ? end_now : ($urandom_range(0, 3) == 0);
         wr_end_flag = (owner == ST_WRITE) ? end_now : ($urandom_range(0, 3) == 0);
         rd_end_flag = (owner == ST_READ)  ? end_now : ($urandom_range(0, 3) == 0);
         ref_cmd = 4'($urandom); ref_addr = AW'($urandom);
         wr_cmd = 4'($urandom); wr_addr = AW'($urandom); wr_bank_addr = BW'($urandom); wr_data = DW'($urandom);
         rd_cmd = 4'($urandom); rd_addr = AW'($urandom); rd_bank_addr = BW'($urandom);
         #1;
         case (owner)
            ST_AREF:  exp_pins = {ref_cmd, ref_addr, 2'b00, 16'h0000, 1'b0};
            ST_WRITE: exp_pins = {wr_cmd, wr_addr, wr_bank_addr, wr_data, 1'b1};
            ST_READ:  exp_pins = {rd_cmd, rd_addr, rd_bank_addr, 16'h0000, 1'b0};
            default:  exp_pins = {NOP, 12'h000, 2'b00, 16'h0000, 1'b0};
         endcase
         n_checks++;
         if ({sdram_cmd, sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe} !== exp_pins) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_pins cyc%0d: got %h want %h", cyc,
                                    {sdram_cmd, sdram_addr, sdram_ba, sdram_dq_out, sdram_dq_oe}, exp_pins);
         end
         exp_owner = owner;
         exp_en = 3'b000;
         if (owner == ST_ARBIT) begin
            if (pend[0]) begin exp_owner = ST_AREF; exp_en = 3'b100; end
            else if (pend[1] && !(RR && pend[2] && m_last_wr)) begin exp_owner = ST_WRITE; exp_en = 3'b010; end
            else if (pend[2]) begin exp_owner = ST_READ; exp_en = 3'b001; end
         end else if (end_now) begin
            exp_owner = ST_ARBIT;
         end
         step();
         n_checks++;
         if ({arb_state, ref_en, wr_en, rd_en} !== {exp_owner, exp_en}) begin
            n_fail++; errs++;
            if (errs < 10) $display("FAIL rand_arb cyc%0d: got st=%0d en=%b want st=%0d en=%b",
                                    cyc, arb_state, {ref_en, wr_en, rd_en}, exp_owner, exp_en);
         end
         owner = exp_owner;
         if (exp_en != 3'b000) begin
            cnt = $urandom_range(0, 3);
            if (exp_en[2]) pend[0] = 1'b0;
            if (exp_en[1]) begin pend[1] = 1'b0; m_last_wr = 1'b1; end
            if (exp_en[0]) begin pend[2] = 1'b0; m_last_wr = 1'b0; end
         end else if (owner != ST_ARBIT && cnt > 0) begin
            cnt--;
         end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_priority();
      test_write_ownership();
      test_reset_mid_read();
      test_wr_rd_alternation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
